// File: rtl/z_op_packer.sv
// Serial-to-parallel packer for the z_ing.op field: LSB-first bits, word closes on OP_W bits or in_last.
// One-cycle latency from closing bit to out_valid; in_ready follows out_ready while a word is held.
module z_op_packer #(
  parameter int   OP_W    = 8,
  parameter logic PAD_VAL = 1'b0,
  parameter int   LEN_W   = $clog2(OP_W + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_op,
  output logic [LEN_W-1:0] out_len,
  output logic             out_short
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_inc;
  logic [OP_W-1:0]  work_q;
  logic [OP_W-1:0]  word_d;
  logic             out_valid_q;
  logic [OP_W-1:0]  out_op_q;
  logic [LEN_W-1:0] out_len_q;
  logic             out_short_q;
  logic             in_xfer;
  logic             close;

  assign in_ready = !rst && ((state_q == COLLECT) || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign close    = in_last || (cnt_inc == LEN_W'(OP_W));

  // Working word with the incoming bit merged in and everything above it padded;
  // cnt_q is 0 while holding, so this also forms bit 0 of an overlapping next word.
  always_comb begin
    word_d = {OP_W{PAD_VAL}};
    for (int i = 0; i < OP_W; i++) begin
      if (LEN_W'(i) < cnt_q) begin
        word_d[i] = work_q[i];
      end else if (LEN_W'(i) == cnt_q) begin
        word_d[i] = in_bit;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= {OP_W{PAD_VAL}};
      out_len_q   <= '0;
      out_short_q <= 1'b0;
    end else begin
      if ((state_q == HOLD) && out_ready) begin
        out_valid_q <= 1'b0;
        state_q     <= COLLECT;
      end
      // A closing bit accepted in the same cycle as the output transfer re-arms HOLD.
      if (in_xfer) begin
        work_q <= word_d;
        if (close) begin
          out_op_q    <= word_d;
          out_len_q   <= cnt_inc;
          out_short_q <= (cnt_inc != LEN_W'(OP_W));
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
          cnt_q       <= '0;
        end else begin
          cnt_q <= cnt_inc;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_len   = out_len_q;
  assign out_short = out_short_q;

endmodule

// File: tb/tb_z_op_packer.sv
// Bench for z_op_packer: vector table, hand-written handshake/reset sequences, random run vs queue model.
module tb_z_op_packer;

  localparam int OP_W  = 8;
  localparam int LEN_W = 4;

  logic             clock = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_bit;
  logic             in_last;
  logic             out_ready;
  logic             in_ready0, in_ready1;
  logic             out_valid0, out_valid1;
  logic [OP_W-1:0]  out_op0, out_op1;
  logic [LEN_W-1:0] out_len0, out_len1;
  logic             out_short0, out_short1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  z_op_packer #(.OP_W(OP_W), .PAD_VAL(1'b0)) u_dut0 (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .out_op(out_op0), .out_len(out_len0), .out_short(out_short0)
  );

  z_op_packer #(.OP_W(OP_W), .PAD_VAL(1'b1)) u_dut1 (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
    .out_op(out_op1), .out_len(out_len1), .out_short(out_short1)
  );

  typedef struct {
    int         n;
    logic [7:0] data;
    logic [7:0] exp0;
    logic [7:0] exp1;
    int         len;
    logic       sh;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_word(input string name, input logic [7:0] e0, input logic [7:0] e1,
                          input int len, input logic sh);
    chk({name, "_vld0"}, 64'(out_valid0), 64'd1);
    chk({name, "_vld1"}, 64'(out_valid1), 64'd1);
    chk({name, "_op0"}, 64'(out_op0), 64'(e0));
    chk({name, "_op1"}, 64'(out_op1), 64'(e1));
    chk({name, "_len"}, 64'(out_len0), 64'(len));
    chk({name, "_short"}, 64'(out_short0), 64'(sh));
  endtask

  function automatic logic [7:0] padw(input logic [7:0] v, input int len, input logic p);
    logic [7:0] r;
    r = v;
    for (int k = len; k < 8; k++) r[k] = p;
    return r;
  endfunction

  vec_t       vecs[7];
  logic [23:0] stream;
  logic [7:0]  got_q[$];
  logic [7:0]  held;
  logic [7:0]  fresh;
  bit          q_bits[$];
  bit          hold_m;
  int          held_len;
  logic [7:0]  held_val;
  logic        exp_rdy;

  initial begin
    vecs[0] = '{8, 8'h4D, 8'h4D, 8'h4D, 8, 1'b0};
    vecs[1] = '{3, 8'h03, 8'h03, 8'hFB, 3, 1'b1};
    vecs[2] = '{1, 8'h01, 8'h01, 8'hFF, 1, 1'b1};
    vecs[3] = '{1, 8'h00, 8'h00, 8'hFE, 1, 1'b1};
    vecs[4] = '{5, 8'h15, 8'h15, 8'hF5, 5, 1'b1};
    vecs[5] = '{7, 8'h40, 8'h40, 8'hC0, 7, 1'b1};
    vecs[6] = '{2, 8'h02, 8'h02, 8'hFE, 2, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready0), 64'd0);
    tick(); tick();
    chk("rst_vld", 64'(out_valid0), 64'd0);
    chk("rst_op0", 64'(out_op0), 64'h00);
    chk("rst_op1", 64'(out_op1), 64'hFF);
    chk("rst_len", 64'(out_len0), 64'd0);
    chk("rst_short", 64'(out_short0), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready0), 64'd1);

    // Table: each word ends with in_last on its final bit.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        in_valid = 1'b1;
        in_bit   = vecs[v].data[i];
        in_last  = (i == vecs[v].n - 1);
        #1;
        if (i == vecs[v].n - 1) chk($sformatf("vec%0d_pre_vld", v), 64'(out_valid0), 64'd0);
        tick();
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk_word($sformatf("vec%0d", v), vecs[v].exp0, vecs[v].exp1, vecs[v].len, vecs[v].sh);
      tick();
      chk($sformatf("vec%0d_drop", v), 64'(out_valid0), 64'd0);
    end

    // 24 continuous bits, no in_last: three back-to-back full words.
    stream = 24'($urandom);
    got_q.delete();
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1; in_bit = stream[i]; in_last = 1'b0;
      #1;
      chk($sformatf("stream_rdy%0d", i), 64'(in_ready0), 64'd1);
      tick();
      chk($sformatf("stream_vld%0d", i), 64'(out_valid0), 64'((i % 8) == 7));
      if (out_valid0) got_q.push_back(out_op0);
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(got_q.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      if (k < got_q.size()) chk($sformatf("stream_word%0d", k), 64'(got_q[k]), 64'(stream[8*k +: 8]));
    tick();

    // Backpressure, then overlapped output transfer with a 1-bit word.
    held = 8'hA6;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_bit = held[i]; in_last = 1'b0;
      tick();
    end
    out_ready = 1'b0;
    chk_word("bp_first", held, held, 8, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_bit = 1'b0; in_last = 1'b0;
      #1;
      chk($sformatf("bp_rdy%0d", c), 64'(in_ready0), 64'd0);
      tick();
      chk($sformatf("bp_vld%0d", c), 64'(out_valid0), 64'd1);
      chk($sformatf("bp_op%0d", c), 64'(out_op0), 64'(held));
    end
    out_ready = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
    #1;
    chk("ovl_rdy", 64'(in_ready0), 64'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk_word("ovl", 8'h01, 8'hFF, 1, 1'b1);
    tick();
    chk("ovl_drop", 64'(out_valid0), 64'd0);

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rstmid_rdy", 64'(in_ready0), 64'd0);
    tick();
    rst = 1'b0;
    chk("rstmid_vld", 64'(out_valid0), 64'd0);
    chk("rstmid_len", 64'(out_len0), 64'd0);
    fresh = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_bit = fresh[i]; in_last = 1'b0;
      tick();
      if (i < 7) chk($sformatf("fresh_novld%0d", i), 64'(out_valid0), 64'd0);
    end
    in_valid = 1'b0;
    chk_word("fresh", fresh, fresh, 8, 1'b0);

    // Reset while holding a word.
    out_ready = 1'b0;
    tick();
    chk("hold_vld", 64'(out_valid0), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    chk("rsthold_vld", 64'(out_valid0), 64'd0);
    chk("rsthold_op0", 64'(out_op0), 64'h00);
    chk("rsthold_op1", 64'(out_op1), 64'hFF);
    chk("rsthold_short", 64'(out_short0), 64'd0);

    // Random traffic against a queue-based model.
    hold_m = 1'b0; held_len = 0; held_val = '0; q_bits.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom_range(0, 1));
      in_last   = ($urandom_range(0, 6) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !hold_m || out_ready;
      chk("rnd_rdy0", 64'(in_ready0), 64'(exp_rdy));
      chk("rnd_rdy1", 64'(in_ready1), 64'(exp_rdy));
      chk("rnd_vld", 64'(out_valid0), 64'(hold_m));
      if (hold_m) begin
        chk("rnd_op0", 64'(out_op0), 64'(padw(held_val, held_len, 1'b0)));
        chk("rnd_op1", 64'(out_op1), 64'(padw(held_val, held_len, 1'b1)));
        chk("rnd_len", 64'(out_len1), 64'(held_len));
        chk("rnd_short", 64'(out_short1), 64'(held_len < OP_W));
      end
      if (hold_m && out_ready) hold_m = 1'b0;
      if (in_valid && exp_rdy) begin
        q_bits.push_back(in_bit);
        if (in_last || q_bits.size() == OP_W) begin
          held_len = q_bits.size();
          held_val = '0;
          for (int k = 0; k < held_len; k++) held_val[k] = q_bits[k];
          hold_m = 1'b1;
          q_bits.delete();
        end
      end
      tick();
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z_op_packer.md
Name: z_op_packer

Overview:
- Upstream stage that builds the packed `op` field of the `z_ing` bundle from a serial bit stream and hands each complete word to the consumer through a valid/ready handshake.
- Bits arrive LSB-first with a `last` marker. Each word closes when OP_W bits have been collected or when `last` arrives.
- The consumer assigns `out_op` to its `z_ing.op` field directly.

Parameters:
- OP_W, 8, width of the packed op word; legal range 2..64.
- PAD_VAL, 1'b0, fill value for the unreceived upper bits of a short word.
- LEN_W, $clog2(OP_W+1), width of out_len; derived, do not override.

Ports:
- clock  input  1  single clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_bit/in_last are valid.
- in_ready  output  1  packer accepts a bit this cycle.
- in_bit  input  1  next op bit, LSB-first.
- in_last  input  1  this bit closes the current word.
- out_valid  output  1  out_op/out_len/out_short are valid.
- out_ready  input  1  consumer takes the word.
- out_op  output  OP_W  packed op word.
- out_len  output  LEN_W  number of received bits, 1..OP_W.
- out_short  output  1  1 if out_len < OP_W.

Behaviour:
- Clock and reset: one clock `clock`. Reset `rst` is synchronous and active-high.
- Reset values (applied while rst=1 at a clock edge):
  - out_valid=0, out_op={OP_W{PAD_VAL}}, out_len=0, out_short=0.
  - Internal bit count=0, state=COLLECT.
  - in_ready=0 during rst, driven combinationally from rst.
- States:
  - COLLECT: accumulating bits into the shift/index register.
  - HOLD: a word is registered on the outputs with out_valid=1.
- Transfers: an input transfer occurs on in_valid & in_ready; an output transfer occurs on out_valid & out_ready.
- COLLECT:
  - in_ready=1.
  - Each transfer writes in_bit to index `cnt` of the working word and increments cnt.
  - If the transfer makes cnt==OP_W or in_last=1, the word closes:
    - out_op = received bits, with indices >= received count set to PAD_VAL.
    - out_len = count including this bit.
    - out_short = (out_len < OP_W).
    - out_valid goes to 1 the next cycle; state moves to HOLD; cnt resets to 0.
  - Latency: out_valid rises exactly 1 cycle after the accepting edge of the closing bit.
- HOLD:
  - out_op, out_len and out_short are stable until the output transfer.
  - in_ready = out_ready (combinational pass-through).
  - Output transfer with no input transfer: out_valid=0, go to COLLECT.
  - Output transfer with a simultaneous input transfer: that bit is bit 0 of the next word, so cnt=1.
    - If that bit also closes the word (in_last=1, or OP_W... n/a since OP_W>=2), stay in HOLD with the new 1-bit word registered and out_valid kept at 1.
    - Otherwise go to COLLECT.
- Throughput: sustained one bit per cycle with out_ready held high; no bubble between words.
- Backpressure: out_valid and the output data must not change while out_valid=1 and out_ready=0.
- Boundary conditions:
  - in_last on the first bit of a word: out_len=1, out_short=1.
  - in_last on bit OP_W-1: out_len=OP_W, out_short=0, treated as a normal full word.
  - in_valid=0 mid-word: cnt holds; there is no timeout.
  - in_bit/in_last are ignored when in_valid=0.
  - rst mid-word or mid-HOLD: the partial or held word is discarded, outputs return to reset values the next cycle, and no word is emitted.
- Arithmetic: cnt is LEN_W bits wide and never exceeds OP_W.

Test Plan:
- OP_W=8: send bits 1,0,1,1,0,0,1,0 (last on 8th), out_ready=1 -> out_op=8'h4D, out_len=8, out_short=0, out_valid pulses 1 cycle after the 8th accept.
- Send 3 bits 1,1,0 with last on the 3rd, PAD_VAL=0 -> out_op=8'h03, out_len=3, out_short=1. Repeat with PAD_VAL=1 -> out_op=8'hFB.
- 24 continuous bits, in_last=0, out_ready=1 -> three words, back-to-back, no idle cycle on in_ready.
- Hold out_ready=0 for 5 cycles after a word -> in_ready=0 and out_op stable throughout. Raise out_ready together with in_valid, bit=1, last=1 -> next word out_op=8'h01, out_len=1, with out_valid continuously high.
- Assert rst after 4 of 8 bits, then send 8 fresh bits -> only the fresh word is output, with out_len=8.
- Single bit with in_last on the first bit -> out_len=1, out_short=1, out_op[0] = the bit sent.
